// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: scan FSM states, queued event record
// and a width helper used for derived parameters.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } scan_state_t;

  // Wide enough for the largest keypad (8x8 = 64 keys).
  localparam int MAX_KW = 6;

  typedef struct packed {
    logic [MAX_KW-1:0] key;
    logic              is_repeat;
  } key_event_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous event queue; a push into a full queue is only accepted
// when a pop happens in the same cycle.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr];

  // Storage is cleared on reset so the head outputs read as zero when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_queue.sv
// Matrix keypad scanner: walks an active-low column, debounces the lowest
// active row, emits press/auto-repeat events into a small queue.
module keypad_scan_queue
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_TICKS = 50,
  parameter int FIFO_DEPTH   = 4,
  localparam int KW          = clog2_min1(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  input  logic            repeat_en,
  input  logic            ev_ready,
  output logic            ev_valid,
  output logic [KW-1:0]   ev_key,
  output logic            ev_repeat,
  output logic            key_held,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(COLS);
  localparam int DW = clog2_min1(SCAN_DIV);
  localparam int PW = clog2_min1(REPEAT_TICKS + 1);

  logic [DW-1:0]   div;
  logic            tick;
  scan_state_t     state, state_nxt;
  logic [CW-1:0]   col_idx, col_idx_nxt, col_adv;
  logic [RW-1:0]   r_lat, r_lat_nxt, r_low;
  logic [3:0]      cnt, cnt_nxt, rel, rel_nxt;
  logic [4:0]      cnt_inc, rel_inc;
  logic [PW-1:0]   rpt, rpt_nxt, rpt_inc;
  logic            held_nxt;
  logic [ROWS-1:0] rows_act;
  logic            any_act, r_act;
  logic            push, push_rep, pop, fifo_full, fifo_empty;
  key_event_t      push_ev, head_ev;
  logic            unused_key_bits;

  assign tick = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div <= '0;
    else             div <= div + 1'b1;
  end

  assign rows_act = ~row;
  assign any_act  = |rows_act;
  assign r_act    = rows_act[r_lat];
  assign col_adv  = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;

  // Lowest-numbered active row wins when several are pulled low.
  always_comb begin
    r_low = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rows_act[i]) r_low = RW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SCAN;
      col_idx  <= '0;
      r_lat    <= '0;
      cnt      <= '0;
      rel      <= '0;
      rpt      <= '0;
      key_held <= 1'b0;
    end else begin
      state    <= state_nxt;
      col_idx  <= col_idx_nxt;
      r_lat    <= r_lat_nxt;
      cnt      <= cnt_nxt;
      rel      <= rel_nxt;
      rpt      <= rpt_nxt;
      key_held <= held_nxt;
    end
  end

  // The column only moves when leaving SCAN idle or returning to SCAN, so
  // the latched column is always the one currently driven.
  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    r_lat_nxt   = r_lat;
    cnt_nxt     = cnt;
    rel_nxt     = rel;
    rpt_nxt     = rpt;
    held_nxt    = key_held;
    push        = 1'b0;
    push_rep    = 1'b0;
    cnt_inc     = {1'b0, cnt} + 5'd1;
    rel_inc     = {1'b0, rel} + 5'd1;
    rpt_inc     = rpt + 1'b1;
    if (tick) begin
      unique case (state)
        ST_SCAN: begin
          if (any_act) begin
            r_lat_nxt = r_low;
            cnt_nxt   = 4'd1;
            state_nxt = ST_DEBOUNCE;
          end else begin
            col_idx_nxt = col_adv;
          end
        end
        ST_DEBOUNCE: begin
          if (!r_act) begin
            state_nxt   = ST_SCAN;
            col_idx_nxt = col_adv;
          end else if (cnt_inc >= 5'(DEBOUNCE)) begin
            push      = 1'b1;
            held_nxt  = 1'b1;
            rpt_nxt   = '0;
            rel_nxt   = '0;
            state_nxt = ST_HELD;
          end else begin
            cnt_nxt = cnt_inc[3:0];
          end
        end
        ST_HELD: begin
          if (r_act) begin
            rel_nxt = '0;
            if (repeat_en) begin
              if (rpt_inc == PW'(REPEAT_TICKS)) begin
                push     = 1'b1;
                push_rep = 1'b1;
                rpt_nxt  = '0;
              end else begin
                rpt_nxt = rpt_inc;
              end
            end
          end else if (rel_inc >= 5'(DEBOUNCE)) begin
            held_nxt    = 1'b0;
            rel_nxt     = '0;
            state_nxt   = ST_SCAN;
            col_idx_nxt = col_adv;
          end else begin
            rel_nxt = rel_inc[3:0];
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  assign push_ev.key       = MAX_KW'(int'(r_lat) * COLS + int'(col_idx));
  assign push_ev.is_repeat = push_rep;

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(key_event_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ev),
    .pop       (pop),
    .head      (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A same-cycle drop wins over the clear request.
  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (push & fifo_full & ~pop) overflow <= 1'b1;
    else if (ovf_clr)                 overflow <= 1'b0;
  end

  assign pop             = ev_ready & ~fifo_empty;
  assign ev_valid        = ~fifo_empty;
  assign ev_key          = head_ev.key[KW-1:0];
  assign ev_repeat       = head_ev.is_repeat;
  assign col             = ~(COLS'(1) << col_idx);
  assign unused_key_bits = ^head_ev.key;

endmodule

// File: tb/tb_keypad_scan_queue.sv
// Bench for keypad_scan_queue: a keypad model pulls a row low when its
// column is driven, and expected events come from press/hold durations.
module tb_keypad_scan_queue;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE     = 3;
  localparam int REPEAT_TICKS = 5;
  localparam int FIFO_DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col;
  logic       repeat_en = 1'b0;
  logic       ev_ready  = 1'b0;
  logic       ovf_clr   = 1'b0;
  logic       ev_valid, ev_repeat, key_held, overflow;
  logic [3:0] ev_key;

  logic       key_down = 1'b0;
  logic [1:0] pr = '0, pc = '0;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         exp_q[$];
  logic       exp_ovf = 1'b0;

  keypad_scan_queue #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .REPEAT_TICKS(REPEAT_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .repeat_en(repeat_en),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_key(ev_key),
    .ev_repeat(ev_repeat), .key_held(key_held), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always_comb begin
    row = 4'hF;
    if (key_down && col[pc] == 1'b0) row[pr] = 1'b0;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] colPat(input int c);
    logic [3:0] p;
    p = 4'hF;
    p[c] = 1'b0;
    return p;
  endfunction

  task automatic nextTick();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % SCAN_DIV != 0);
  endtask

  task automatic modelPush(input int key, input int rep);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(key * 2 + rep);
    else exp_ovf = 1'b1;
  endtask

  task automatic resetDut();
    rst = 1'b1; key_down = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0; repeat_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_col", col, 4'hE);
    checkOutput("rst_key_held", key_held, 0);
    checkOutput("rst_ev_valid", ev_valid, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_ev_key", ev_key, 0);
    checkOutput("rst_ev_repeat", ev_repeat, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Press key (r,c), keep it down for hold ticks after acceptance, release.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] c,
                               input logic rep_en, input int hold);
    int first, n, m;
    repeat_en = rep_en; pr = r; pc = c; key_down = 1'b1;
    first = -1;
    n = 0;
    while (!key_held && n < 64) begin
      if (first < 0 && col == colPat(c)) first = n;
      nextTick();
      n++;
    end
    checkOutput("press_seen", key_held, 1);
    checkOutput("press_latency", n - first, DEBOUNCE);
    modelPush(r * COLS + c, 0);
    repeat (hold) nextTick();
    key_down = 1'b0;
    if (rep_en) begin
      for (int k = 0; k < hold / REPEAT_TICKS; k++) modelPush(r * COLS + c, 1);
    end
    m = 0;
    while (key_held && m < 64) begin
      nextTick();
      m++;
    end
    checkOutput("release_latency", m, DEBOUNCE);
  endtask

  task automatic drainCheck();
    int item;
    checkOutput("overflow", overflow, exp_ovf);
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      checkOutput("ev_valid", ev_valid, 1);
      checkOutput("ev_key", ev_key, item / 2);
      checkOutput("ev_repeat", ev_repeat, item % 2);
      ev_ready = 1'b1;
      @(posedge clk);
      #1;
      ev_ready = 1'b0;
    end
    checkOutput("drained", ev_valid, 0);
  endtask

  task automatic clearOverflow();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    checkOutput("ovf_clr", overflow, 0);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    resetDut();

    // Idle: column walks one step per scan tick, no events.
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_col", col, colPat((k / SCAN_DIV) % COLS));
      checkOutput("idle_ev_valid", ev_valid, 0);
    end

    // Single press of key 6, no repeat.
    applyStimulus(2'd1, 2'd2, 1'b0, 7);
    drainCheck();

    // Bounce: two samples low, one high, then a clean press.
    pr = 2'd1; pc = 2'd2; repeat_en = 1'b0; key_down = 1'b1;
    n = 0;
    while (col != colPat(2) && n < 16) begin
      nextTick();
      n++;
    end
    nextTick();
    nextTick();
    key_down = 1'b0;
    nextTick();
    checkOutput("bounce_no_event", ev_valid, 0);
    checkOutput("bounce_not_held", key_held, 0);
    applyStimulus(2'd1, 2'd2, 1'b0, 0);
    drainCheck();

    // Auto-repeat on key 5.
    applyStimulus(2'd1, 2'd1, 1'b1, 15);
    drainCheck();

    // Five presses without draining: four queued, fifth dropped.
    applyStimulus(2'd0, 2'd0, 1'b0, 0);
    applyStimulus(2'd0, 2'd3, 1'b0, 0);
    applyStimulus(2'd2, 2'd1, 1'b0, 0);
    applyStimulus(2'd3, 2'd0, 1'b0, 0);
    applyStimulus(2'd3, 2'd3, 1'b0, 0);
    drainCheck();
    clearOverflow();

    // Reset while a key is held with a full queue and overflow set.
    for (int i = 0; i < 4; i++) applyStimulus(2'(i), 2'(3 - i), 1'b0, 0);
    pr = 2'd2; pc = 2'd1; key_down = 1'b1;
    n = 0;
    while (!key_held && n < 64) begin
      nextTick();
      n++;
    end
    checkOutput("t6_held", key_held, 1);
    checkOutput("t6_overflow", overflow, 1);
    resetDut();

    // Randomized presses with occasional draining.
    for (int t = 0; t < 12; t++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0 || t == 11) begin
        drainCheck();
        if (exp_ovf) clearOverflow();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
